// File: rtl/cart_rom_fetch_pkg.sv
// cart_rom_fetch_pkg: shared state encoding and defaults for the cartridge ROM fetch path
package cart_rom_fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fetch_state_t;
    localparam int FETCH_TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/cart_rom_fetch_if.sv
// cart_rom_fetch_if: SDRAM read port between the fetch engine and the memory controller
interface cart_rom_fetch_if;
    logic [24:0] sdram_addr;
    logic        sdram_rd;
    logic        sdram_ready;
    logic [7:0]  sdram_dout;
    modport master (output sdram_addr, sdram_rd, input sdram_ready, sdram_dout);
    modport slave  (input sdram_addr, sdram_rd, output sdram_ready, sdram_dout);
endinterface

// File: rtl/cart_fetch_cache.sv
// cart_fetch_cache: single-entry last-read cache with invalidate and in-flight fill poisoning
module cart_fetch_cache (
    input  logic        clk,
    input  logic        reset,
    input  logic        fill,
    input  logic [24:0] fill_addr,
    input  logic [7:0]  fill_data,
    input  logic        invalidate,
    input  logic        poison_set,
    input  logic        poison_clr,
    output logic        valid,
    output logic [24:0] tag,
    output logic [7:0]  data
);
    logic poison;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            tag    <= '0;
            data   <= '0;
            poison <= 1'b0;
        end else begin
            poison <= poison_clr ? 1'b0 : (poison_set ? 1'b1 : poison);
            // a bank write landing in the same cycle as the fill also poisons it
            if (invalidate)
                valid <= 1'b0;
            else if (fill && !poison && !poison_set) begin
                valid <= 1'b1;
                tag   <= fill_addr;
                data  <= fill_data;
            end
        end
    end
endmodule

// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: turns CPU cartridge reads into SDRAM fetches, with optional one-byte cache
module cart_rom_fetch
    import cart_rom_fetch_pkg::*;
#(
    parameter int TIMEOUT  = FETCH_TIMEOUT_DEFAULT,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             cpu_mreq,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [24:0]      mem_addr,
    input  logic             mem_unmaped,
    input  logic [24:0]      rom_base,
    cart_rom_fetch_if.master sdram,
    output logic             cpu_wait,
    output logic [7:0]       data,
    output logic             data_valid,
    output logic             timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    fetch_state_t state, state_nx;
    logic          rd_req, rd_req_q, start, bank_wr, hit, fill, timed_out, quick_valid;
    logic [24:0]   phys;
    logic [CW-1:0] cnt;
    logic [7:0]    cache_data;

    assign rd_req    = cs & cpu_mreq & cpu_rd & ~cpu_wr;
    assign start     = rd_req & ~rd_req_q & (state == IDLE);
    assign bank_wr   = cs & cpu_mreq & cpu_wr;
    assign phys      = rom_base + mem_addr;
    assign fill      = (state == WAIT) && sdram.sdram_ready;
    assign timed_out = (state == WAIT) && !sdram.sdram_ready && cnt == CW'(TIMEOUT);

    if (CACHE_EN) begin : g_cache
        logic        cache_valid;
        logic [24:0] cache_tag;
        cart_fetch_cache u_cache (
            .clk       (clk),
            .reset     (reset),
            .fill      (fill),
            .fill_addr (sdram.sdram_addr),
            .fill_data (sdram.sdram_dout),
            .invalidate(bank_wr),
            .poison_set(bank_wr && (state == REQ || state == WAIT)),
            .poison_clr(start),
            .valid     (cache_valid),
            .tag       (cache_tag),
            .data      (cache_data)
        );
        assign hit = cache_valid && cache_tag == phys;
    end else begin : g_nocache
        assign hit        = 1'b0;
        assign cache_data = 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        cpu_wait       = 1'b0;
        sdram.sdram_rd = 1'b0;
        data_valid     = quick_valid;
        case (state)
            IDLE: if (start && !mem_unmaped && !hit) begin
                cpu_wait = 1'b1;
                state_nx = REQ;
            end
            REQ: begin
                cpu_wait       = 1'b1;
                sdram.sdram_rd = 1'b1;
                state_nx       = WAIT;
            end
            WAIT: begin
                cpu_wait = 1'b1;
                state_nx = (fill || timed_out) ? DONE : WAIT;
            end
            DONE: begin
                data_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_req_q         <= 1'b0;
            sdram.sdram_addr <= '0;
            data             <= 8'hFF;
            quick_valid      <= 1'b0;
            timeout_err      <= 1'b0;
            cnt              <= '0;
        end else begin
            rd_req_q    <= rd_req;
            quick_valid <= 1'b0;
            // unmapped and cache-hit reads complete without leaving IDLE
            if (start) begin
                if (mem_unmaped) begin
                    data        <= 8'hFF;
                    quick_valid <= 1'b1;
                end else if (hit) begin
                    data        <= cache_data;
                    quick_valid <= 1'b1;
                end else
                    sdram.sdram_addr <= phys;
            end
            if (state == REQ)
                cnt <= '0;
            else if (state == WAIT && !sdram.sdram_ready && cnt != CW'(TIMEOUT))
                cnt <= cnt + 1'b1;
            if (fill)
                data <= sdram.sdram_dout;
            else if (timed_out) begin
                data        <= 8'hFF;
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cart_rom_fetch.sv
// tb_cart_rom_fetch: directed scenarios for the cartridge ROM fetch path with a scripted SDRAM
module tb_cart_rom_fetch;
    import cart_rom_fetch_pkg::*;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cs = 1'b0, cpu_mreq = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, mem_unmaped = 1'b0;
    logic [24:0] mem_addr = '0, rom_base = 25'h100000;
    logic        cpu_wait, data_valid, timeout_err;
    logic [7:0]  data;

    int          n_checks = 0, n_fail = 0;
    int          n_rd, n_wait, n_dv, dv_cycle;
    logic [24:0] rd_addr;
    logic [7:0]  dv_data;
    logic        wait0;

    cart_rom_fetch_if bus ();

    cart_rom_fetch #(.TIMEOUT(8), .CACHE_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .cpu_mreq   (cpu_mreq),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .mem_addr   (mem_addr),
        .mem_unmaped(mem_unmaped),
        .rom_base   (rom_base),
        .sdram      (bus),
        .cpu_wait   (cpu_wait),
        .data       (data),
        .data_valid (data_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // One CPU read over a fixed 24-cycle window; delay<0 means SDRAM never answers,
    // wr_at>=0 pulses a bank write that many cycles after sdram_rd.
    task automatic run_read(input logic [24:0] a, input logic unm, input int delay,
                            input logic [7:0] d, input int wr_at);
        int rd_k;
        rd_k = -1; n_rd = 0; n_wait = 0; n_dv = 0; dv_cycle = -1; rd_addr = '0; dv_data = '0;
        mem_addr = a; mem_unmaped = unm; cs = 1'b1; cpu_mreq = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0;
        #1 wait0 = cpu_wait;
        for (int k = 0; k < 24; k++) begin
            bus.sdram_ready = rd_k >= 0 && delay >= 0 && k == rd_k + delay;
            bus.sdram_dout  = bus.sdram_ready ? d : 8'h00;
            cpu_wr = rd_k >= 0 && wr_at >= 0 && k == rd_k + wr_at;
            cpu_rd = ~cpu_wr;
            #1;
            if (bus.sdram_rd) begin
                n_rd++;
                if (rd_k < 0) begin rd_k = k; rd_addr = bus.sdram_addr; end
            end
            if (cpu_wait) n_wait++;
            if (data_valid) begin n_dv++; dv_cycle = k; dv_data = data; end
            @(posedge clk); #1;
        end
        bus.sdram_ready = 1'b0; cs = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; mem_unmaped = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got %b expected 0", cpu_wait); end
        n_checks++; if (bus.sdram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", bus.sdram_rd); end
        n_checks++; if (bus.sdram_addr !== 25'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.sdram_addr); end
        n_checks++; if (data !== 8'hFF) begin n_fail++; $display("FAIL reset_data: got %h expected ff", data); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", timeout_err); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_miss;
        run_read(25'h02345, 1'b0, 5, 8'hA5, -1);
        n_checks++; if (wait0 !== 1'b1) begin n_fail++; $display("FAIL miss_wait_start: got %b expected 1", wait0); end
        n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL miss_rd_count: got %0d expected 1", n_rd); end
        n_checks++; if (rd_addr !== 25'h102345) begin n_fail++; $display("FAIL miss_addr: got %h expected 102345", rd_addr); end
        n_checks++; if (n_wait !== 7) begin n_fail++; $display("FAIL miss_wait_cycles: got %0d expected 7", n_wait); end
        n_checks++; if (n_dv !== 1) begin n_fail++; $display("FAIL miss_dv_count: got %0d expected 1", n_dv); end
        n_checks++; if (dv_cycle !== 7) begin n_fail++; $display("FAIL miss_dv_cycle: got %0d expected 7", dv_cycle); end
        n_checks++; if (dv_data !== 8'hA5) begin n_fail++; $display("FAIL miss_data: got %h expected a5", dv_data); end
        n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL miss_data_held: got %h expected a5", data); end
    endtask

    task automatic test_hit;
        run_read(25'h02345, 1'b0, 5, 8'h00, -1);
        n_checks++; if (wait0 !== 1'b0) begin n_fail++; $display("FAIL hit_wait_start: got %b expected 0", wait0); end
        n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL hit_rd_count: got %0d expected 0", n_rd); end
        n_checks++; if (n_wait !== 0) begin n_fail++; $display("FAIL hit_wait_cycles: got %0d expected 0", n_wait); end
        n_checks++; if (dv_cycle !== 1) begin n_fail++; $display("FAIL hit_dv_cycle: got %0d expected 1", dv_cycle); end
        n_checks++; if (dv_data !== 8'hA5) begin n_fail++; $display("FAIL hit_data: got %h expected a5", dv_data); end
        bus.sdram_ready = 1'b1; bus.sdram_dout = 8'h11;
        @(posedge clk); #1;
        bus.sdram_ready = 1'b0;
        n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL stray_ready_data: got %h expected a5", data); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL stray_ready_dv: got %b expected 0", data_valid); end
    endtask

    task automatic test_unmapped;
        run_read(25'h00010, 1'b1, 5, 8'h22, -1);
        n_checks++; if (wait0 !== 1'b0) begin n_fail++; $display("FAIL unmap_wait_start: got %b expected 0", wait0); end
        n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL unmap_rd_count: got %0d expected 0", n_rd); end
        n_checks++; if (n_wait !== 0) begin n_fail++; $display("FAIL unmap_wait_cycles: got %0d expected 0", n_wait); end
        n_checks++; if (n_dv !== 1) begin n_fail++; $display("FAIL unmap_dv_count: got %0d expected 1", n_dv); end
        n_checks++; if (dv_data !== 8'hFF) begin n_fail++; $display("FAIL unmap_data: got %h expected ff", dv_data); end
    endtask

    task automatic test_poison;
        run_read(25'h00100, 1'b0, 5, 8'h3C, 2);
        n_checks++; if (rd_addr !== 25'h100100) begin n_fail++; $display("FAIL poison_addr: got %h expected 100100", rd_addr); end
        n_checks++; if (dv_data !== 8'h3C) begin n_fail++; $display("FAIL poison_data: got %h expected 3c", dv_data); end
        run_read(25'h00100, 1'b0, 5, 8'h3C, -1);
        n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL poison_refetch: got %0d sdram_rd expected 1", n_rd); end
        n_checks++; if (dv_data !== 8'h3C) begin n_fail++; $display("FAIL poison_refetch_data: got %h expected 3c", dv_data); end
        run_read(25'h00100, 1'b0, 5, 8'h00, -1);
        n_checks++; if (n_rd !== 0) begin n_fail++; $display("FAIL poison_cleared_hit: got %0d sdram_rd expected 0", n_rd); end
        n_checks++; if (dv_data !== 8'h3C) begin n_fail++; $display("FAIL poison_cleared_data: got %h expected 3c", dv_data); end
    endtask

    task automatic test_ready_at_timeout;
        run_read(25'h00300, 1'b0, 9, 8'h5A, -1);
        n_checks++; if (dv_data !== 8'h5A) begin n_fail++; $display("FAIL edge_ready_data: got %h expected 5a", dv_data); end
        n_checks++; if (dv_cycle !== 11) begin n_fail++; $display("FAIL edge_ready_dv_cycle: got %0d expected 11", dv_cycle); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL edge_ready_err: got %b expected 0", timeout_err); end
    endtask

    task automatic test_timeout;
        run_read(25'h00200, 1'b0, -1, 8'h00, -1);
        n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL timeout_rd_count: got %0d expected 1", n_rd); end
        n_checks++; if (n_wait !== 11) begin n_fail++; $display("FAIL timeout_wait_cycles: got %0d expected 11", n_wait); end
        n_checks++; if (dv_cycle !== 11) begin n_fail++; $display("FAIL timeout_dv_cycle: got %0d expected 11", dv_cycle); end
        n_checks++; if (dv_data !== 8'hFF) begin n_fail++; $display("FAIL timeout_data: got %h expected ff", dv_data); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
        run_read(25'h00200, 1'b0, 2, 8'h77, -1);
        n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL timeout_not_cached: got %0d sdram_rd expected 1", n_rd); end
        n_checks++; if (dv_data !== 8'h77) begin n_fail++; $display("FAIL timeout_next_data: got %h expected 77", dv_data); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b expected 1", timeout_err); end
    endtask

    task automatic test_reset_mid_fetch;
        mem_addr = 25'h00500; cs = 1'b1; cpu_mreq = 1'b1; cpu_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dut.state !== WAIT) begin n_fail++; $display("FAIL rst_mid_pre_state: got %0d expected WAIT", dut.state); end
        reset = 1'b1; cs = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0;
        #1;
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected IDLE", dut.state); end
        n_checks++; if (cpu_wait !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait: got %b expected 0", cpu_wait); end
        n_checks++; if (bus.sdram_addr !== 25'h0) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected 0", bus.sdram_addr); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", timeout_err); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.sdram_ready = 1'b1; bus.sdram_dout = 8'h99;
        @(posedge clk); #1;
        bus.sdram_ready = 1'b0;
        n_checks++; if (data !== 8'hFF) begin n_fail++; $display("FAIL rst_late_ready_data: got %h expected ff", data); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_late_ready_dv: got %b expected 0", data_valid); end
        n_checks++; if (bus.sdram_rd !== 1'b0) begin n_fail++; $display("FAIL rst_late_ready_rd: got %b expected 0", bus.sdram_rd); end
        run_read(25'h00200, 1'b0, 2, 8'h44, -1);
        n_checks++; if (n_rd !== 1) begin n_fail++; $display("FAIL rst_cache_invalid: got %0d sdram_rd expected 1", n_rd); end
        n_checks++; if (dv_data !== 8'h44) begin n_fail++; $display("FAIL rst_refetch_data: got %h expected 44", dv_data); end
    endtask

    initial begin
        bus.sdram_ready = 1'b0;
        bus.sdram_dout  = 8'h00;
        test_reset;
        test_miss;
        test_hit;
        test_unmapped;
        test_poison;
        test_ready_at_timeout;
        test_timeout;
        test_reset_mid_fetch;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
